fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode-stage control unit. Holds the program counter, addresses instruction memory, and owns the IF/ID pipeline register that presents the instruction word to decode. It resolves next-PC from the decode-stage `npcOp` and `isRsRtEq` (branches and jumps resolve in ID), and squashes the wrong-path instruction with a one-cycle flush. It also honours stall requests from the hazard unit.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: word inserted into IF/ID on flush or reset.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `stallF`, input, 1: hazard-unit stall; holds the PC and IF/ID.
- `npcOpD`, input, 3: next-PC operation from the control unit for the instruction in ID.
- `isRsRtEq`, input, 1: rs==rt comparison for the instruction in ID.
- `rsDataD`, input, 32: forwarded rs value in ID, used as the `jr` target.
- `imem_rdata`, input, 32: instruction word; combinational (asynchronous) read of `imem_addr`.
- `imem_addr`, output, 32: current PC.
- `instrD`, output, 32: IF/ID instruction.
- `pcD`, output, 32: IF/ID PC.
- `pcPlus4D`, output, 32: IF/ID PC+4, also the `jal` link value.
- `validD`, output, 1: IF/ID holds a real (not flushed/reset) instruction.
- `redirectF`, output, 1: combinational; a taken control transfer is applied this cycle.

## Operation
- `npcOp` encoding (shared constants):
  - 000: SEQ
  - 001: J
  - 010: BEQ
  - 011: JR
  - 100: BNE
  - 101: JAL
  - 110, 111: treated as SEQ.
- Taken condition is evaluated only when `validD`=1:
  - J, JR, JAL: always taken.
  - BEQ: taken when `isRsRtEq`=1.
  - BNE: taken when `isRsRtEq`=0.
- Targets, all 32-bit with modulo-2^32 wrap:
  - Branch: `pcPlus4D + (sext(instrD[15:0]) << 2)`.
  - J/JAL: `{pcPlus4D[31:28], instrD[25:0], 2'b00}`.
  - JR: `{rsDataD[31:2], 2'b00}`; the low bits are forced to zero.
  - Sequential: `PC + 4`; 32'hFFFF_FFFC wraps to 0.
- `redirectF` = taken AND NOT `stallF`.
- No branch delay slot. On redirect, the word fetched this cycle is discarded and IF/ID loads `NOP_INSTR` with `validD`=0.
- Per-cycle update priority, highest first:
  - `rst`: PC=`RESET_PC`; IF/ID cleared.
  - `stallF`: PC and IF/ID hold. Any pending redirect is ignored, because the ID instruction is held and re-evaluated next cycle.
  - `redirectF`: PC=target; IF/ID flushed.
  - Otherwise: PC=PC+4; IF/ID = {`imem_rdata`, PC, PC+4, `validD`=1}.

## Timing
- Reset values:
  - PC = `RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `instrD`=`NOP_INSTR`, `pcD`=0, `pcPlus4D`=0, `validD`=0.
  - `redirectF`=0.
- The first valid instruction appears in `instrD` one cycle after `rst` deasserts.
- Fetch-to-decode latency: 1 cycle.
- Taken-transfer penalty: exactly 1 bubble cycle. The target instruction reaches ID two cycles after the branch entered ID.
- A flushed bubble has `validD`=0. It therefore cannot itself redirect, even though the NOP decodes as SEQ.
- Stall held for N cycles freezes all outputs for N cycles. The transfer resolves on the first unstalled cycle, using the current `isRsRtEq`/`rsDataD`.
- `rst` asserted mid-stall or mid-redirect overrides both in the same edge.
- `redirectF` and all next-PC logic are combinational from IF/ID and ID inputs. There is no combinational path from `imem_rdata` to `imem_addr`.

## Structure
- Shared package/header (`defines.vh`):
  - `NPC_SEQ`/`NPC_J`/`NPC_BEQ`/`NPC_JR`/`NPC_BNE`/`NPC_JAL` codes.
  - `NPC_OP_LENGTH`.
  - NOP constant.
- Sub-module `npc_calc` (combinational): inputs `npcOpD`, `isRsRtEq`, `validD`, `pcD`/`pcPlus4D`, `instrD`, `rsDataD`, PC; outputs `taken` and `next_pc`.
- `fetch_stage` holds only the PC register, the IF/ID register, and the priority logic.

## Test plan
- **Reset and sequential fetch.** Hold `rst` for 2 cycles, then release with memory holding words W0..W3 at 0x0..0xC.
  - After reset: `imem_addr`=0, `validD`=0.
  - Following cycles: `instrD`=W0, W1, W2 with `pcD`=0, 4, 8.
- **BEQ taken.** `instrD` is a beq at `pcD`=0x8 with imm=0x0003, `npcOpD`=010, `isRsRtEq`=1.
  - `redirectF`=1; next `imem_addr`=0x18.
  - Next `validD`=0; the following cycle has `pcD`=0x18.
- **BNE not taken and negative offset.**
  - bne at 0x20, `isRsRtEq`=1: no redirect; PC continues sequentially.
  - bne at 0x20 with imm=0xFFFE, `isRsRtEq`=0: target 0x1C.
- **JR and J.**
  - jr with `rsDataD`=0x0000_1237: target 0x0000_1234.
  - j at `pcD`=0x8000_0000 with `instr[25:0]`=0x0000010: target 0x8000_0040.
- **Stall vs. redirect.** Taken beq in ID with `stallF`=1 for 3 cycles.
  - During the stall: `redirectF`=0 and all outputs frozen.
  - Cycle 4: redirect occurs.
  - Assert `rst` during a stall: reset values appear after 1 edge.
- **Wrap-around.** PC at 0xFFFF_FFFC, sequential: next PC is 0x0 and `pcPlus4D` reads 0x0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared constants for the instruction-fetch stage and the decode-stage
//   control unit: next-PC operation codes, their width, and the NOP word.
package fetch_stage_pkg;

   localparam int unsigned NPC_OP_LENGTH = 3;

   typedef enum logic [NPC_OP_LENGTH-1:0] {
      NPC_SEQ = 3'b000,
      NPC_J   = 3'b001,
      NPC_BEQ = 3'b010,
      NPC_JR  = 3'b011,
      NPC_BNE = 3'b100,
      NPC_JAL = 3'b101
   } npc_op_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_npc.sv
// npc_calc
//   Combinational next-PC resolution for the instruction held in ID.
//   Ports:
//     npcOpD    - next-PC operation of the ID instruction
//     isRsRtEq  - rs==rt comparison result for the ID instruction
//     validD    - ID holds a real instruction; bubbles never transfer
//     pcPlus4D  - PC+4 of the ID instruction (branch base, J/JAL region)
//     instrD    - low 26 bits of the ID instruction (imm16 / jump index)
//     rsDataD   - forwarded rs value, word-aligned part only (JR target)
//     pc        - current fetch PC
//     taken     - a control transfer is taken this cycle
//     next_pc   - target when taken, otherwise pc + 4
module npc_calc
   import fetch_stage_pkg::*;
(
   input  logic [NPC_OP_LENGTH-1:0] npcOpD,
   input  logic                     isRsRtEq,
   input  logic                     validD,
   input  logic [31:0]              pcPlus4D,
   input  logic [25:0]              instrD,
   input  logic [31:2]              rsDataD,
   input  logic [31:0]              pc,
   output logic                     taken,
   output logic [31:0]              next_pc
);

   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic        take_raw;
   logic [31:0] target;

   assign branch_target = pcPlus4D + {{14{instrD[15]}}, instrD[15:0], 2'b00};
   assign jump_target   = {pcPlus4D[31:28], instrD, 2'b00};
   assign jr_target     = {rsDataD, 2'b00};

   always_comb begin
      take_raw = 1'b0;
      target   = '0;
      case (npcOpD)
         NPC_J, NPC_JAL: begin
            take_raw = 1'b1;
            target   = jump_target;
         end
         NPC_JR: begin
            take_raw = 1'b1;
            target   = jr_target;
         end
         NPC_BEQ: begin
            take_raw = isRsRtEq;
            target   = branch_target;
         end
         NPC_BNE: begin
            take_raw = ~isRsRtEq;
            target   = branch_target;
         end
         default: begin
            take_raw = 1'b0;
            target   = '0;
         end
      endcase
   end

   assign taken   = take_raw & validD;
   assign next_pc = taken ? target : pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch: PC register, IF/ID pipeline register and the
//   reset > stall > redirect > sequential update priority.
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     stallF      - hold PC and IF/ID (pending redirects wait)
//     npcOpD      - next-PC operation of the ID instruction
//     isRsRtEq    - rs==rt for the ID instruction
//     rsDataD     - forwarded rs value (JR target)
//     imem_rdata  - asynchronous instruction-memory read data
//     imem_addr   - current PC
//     instrD, pcD, pcPlus4D, validD - IF/ID register contents
//     redirectF   - taken transfer applied this cycle
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stallF,
   input  logic [NPC_OP_LENGTH-1:0] npcOpD,
   input  logic                     isRsRtEq,
   input  logic [31:0]              rsDataD,
   input  logic [31:0]              imem_rdata,
   output logic [31:0]              imem_addr,
   output logic [31:0]              instrD,
   output logic [31:0]              pcD,
   output logic [31:0]              pcPlus4D,
   output logic                     validD,
   output logic                     redirectF
);

   logic [31:0] pc;
   logic        taken;
   logic [31:0] next_pc;

   npc_calc u_npc (
      .npcOpD   (npcOpD),
      .isRsRtEq (isRsRtEq),
      .validD   (validD),
      .pcPlus4D (pcPlus4D),
      .instrD   (instrD[25:0]),
      .rsDataD  (rsDataD[31:2]),
      .pc       (pc),
      .taken    (taken),
      .next_pc  (next_pc)
   );

   assign redirectF = taken & ~stallF;
   assign imem_addr = pc;

   // next_pc already selects target vs. pc+4, so the redirect and
   // sequential branches share the PC update and differ only in IF/ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         instrD   <= NOP_INSTR;
         pcD      <= '0;
         pcPlus4D <= '0;
         validD   <= 1'b0;
      end else if (stallF) begin
         pc       <= pc;
      end else if (redirectF) begin
         pc       <= next_pc;
         instrD   <= NOP_INSTR;
         pcD      <= '0;
         pcPlus4D <= '0;
         validD   <= 1'b0;
      end else begin
         pc       <= next_pc;
         instrD   <= imem_rdata;
         pcD      <= pc;
         pcPlus4D <= pc + 32'd4;
         validD   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallF;
   logic [2:0]  npcOpD;
   logic        isRsRtEq;
   logic [31:0] rsDataD;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcPlus4D;
   logic        validD;
   logic        redirectF;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stallF     (stallF),
      .npcOpD     (npcOpD),
      .isRsRtEq   (isRsRtEq),
      .rsDataD    (rsDataD),
      .imem_rdata (imem_rdata),
      .imem_addr  (imem_addr),
      .instrD     (instrD),
      .pcD        (pcD),
      .pcPlus4D   (pcPlus4D),
      .validD     (validD),
      .redirectF  (redirectF)
   );

   // instruction memory model
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h1111_0000;
         32'h0000_0004: return 32'h2222_0004;
         32'h0000_0008: return 32'h1000_0003; // beq imm=3
         32'h0000_000C: return 32'h3333_000C;
         32'h0000_0018: return 32'h5555_0018;
         32'h0000_001C: return 32'h6666_001C;
         32'h0000_0020: return 32'h1400_FFFE; // bne imm=-2
         32'h0000_0024: return 32'h1400_FFFE; // bne imm=-2
         32'h8000_0000: return 32'h0800_0010; // j idx=0x10
         32'h8000_0040: return 32'h0C00_0100; // jal idx=0x100
         default:       return {8'hEE, a[23:0]};
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic        rst;
      logic        stall;
      logic [2:0]  op;
      logic        eq;
      logic [31:0] rs;
      logic        exp_redirect;
      logic [31:0] exp_addr;
      logic [31:0] exp_instr;
      logic        exp_valid;
      logic        chk_pc;
      logic [31:0] exp_pcd;
      logic [31:0] exp_pc4;
   } row_t;

   row_t rows[$];

   function automatic void add(input logic r, input logic s, input logic [2:0] op, input logic eq,
                               input logic [31:0] rs, input logic red, input logic [31:0] addr,
                               input logic [31:0] ins, input logic v, input logic cp,
                               input logic [31:0] pd, input logic [31:0] p4);
      row_t t;
      t.rst = r; t.stall = s; t.op = op; t.eq = eq; t.rs = rs;
      t.exp_redirect = red; t.exp_addr = addr; t.exp_instr = ins; t.exp_valid = v;
      t.chk_pc = cp; t.exp_pcd = pd; t.exp_pc4 = p4;
      rows.push_back(t);
   endfunction

   task automatic drive(input logic r, input logic s, input logic [2:0] op, input logic eq,
                        input logic [31:0] rs);
      rst = r; stallF = s; npcOpD = op; isRsRtEq = eq; rsDataD = rs;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                             input logic v, input logic cp, input logic [31:0] pd,
                             input logic [31:0] p4);
      check({tag, " imem_addr"}, imem_addr, addr);
      check({tag, " instrD"}, instrD, ins);
      check({tag, " validD"}, {31'd0, validD}, {31'd0, v});
      if (cp) begin
         check({tag, " pcD"}, pcD, pd);
         check({tag, " pcPlus4D"}, pcPlus4D, p4);
      end
   endtask

   initial begin
      //    rst s  op      eq rs             red addr           instr          v  cp pcD            pc4
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0004, 32'h1111_0000, 1, 1, 32'h0000_0000, 32'h0000_0004);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0008, 32'h2222_0004, 1, 1, 32'h0000_0004, 32'h0000_0008);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_000C, 32'h1000_0003, 1, 1, 32'h0000_0008, 32'h0000_000C);
      // taken beq stalled three cycles: everything frozen
      add(0, 1, NPC_BEQ, 1, 32'h0,         0, 32'h0000_000C, 32'h1000_0003, 1, 1, 32'h0000_0008, 32'h0000_000C);
      add(0, 1, NPC_BEQ, 1, 32'h0,         0, 32'h0000_000C, 32'h1000_0003, 1, 1, 32'h0000_0008, 32'h0000_000C);
      add(0, 1, NPC_BEQ, 1, 32'h0,         0, 32'h0000_000C, 32'h1000_0003, 1, 1, 32'h0000_0008, 32'h0000_000C);
      add(0, 0, NPC_BEQ, 1, 32'h0,         1, 32'h0000_0018, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      // bubble carries a taken-looking op but must not redirect
      add(0, 0, NPC_BEQ, 1, 32'h0,         0, 32'h0000_001C, 32'h5555_0018, 1, 1, 32'h0000_0018, 32'h0000_001C);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0020, 32'h6666_001C, 1, 1, 32'h0000_001C, 32'h0000_0020);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0024, 32'h1400_FFFE, 1, 1, 32'h0000_0020, 32'h0000_0024);
      // bne at 0x20 not taken
      add(0, 0, NPC_BNE, 1, 32'h0,         0, 32'h0000_0028, 32'h1400_FFFE, 1, 1, 32'h0000_0024, 32'h0000_0028);
      // bne at 0x24 taken -> 0x20
      add(0, 0, NPC_BNE, 0, 32'h0,         1, 32'h0000_0020, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0024, 32'h1400_FFFE, 1, 1, 32'h0000_0020, 32'h0000_0024);
      // bne at 0x20 taken -> 0x1C
      add(0, 0, NPC_BNE, 0, 32'h0,         1, 32'h0000_001C, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0020, 32'h6666_001C, 1, 1, 32'h0000_001C, 32'h0000_0020);
      // jr 0x1237 -> 0x1234
      add(0, 0, NPC_JR,  0, 32'h0000_1237, 1, 32'h0000_1234, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_1238, 32'hEE00_1234, 1, 1, 32'h0000_1234, 32'h0000_1238);
      add(0, 0, NPC_JR,  0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h8000_0004, 32'h0800_0010, 1, 1, 32'h8000_0000, 32'h8000_0004);
      // j idx=0x10 at 0x8000_0000 -> 0x8000_0040
      add(0, 0, NPC_J,   0, 32'h0,         1, 32'h8000_0040, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h8000_0044, 32'h0C00_0100, 1, 1, 32'h8000_0040, 32'h8000_0044);
      // jal idx=0x100 -> 0x8000_0400
      add(0, 0, NPC_JAL, 0, 32'h0,         1, 32'h8000_0400, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h8000_0404, 32'hEE00_0400, 1, 1, 32'h8000_0400, 32'h8000_0404);
      // wrap-around
      add(0, 0, NPC_JR,  0, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      add(0, 0, NPC_SEQ, 0, 32'h0,         0, 32'h0000_0000, 32'hEEFF_FFFC, 1, 1, 32'hFFFF_FFFC, 32'h0000_0000);
      // reserved op codes behave as SEQ
      add(0, 0, 3'b110,  1, 32'h0,         0, 32'h0000_0004, 32'h1111_0000, 1, 1, 32'h0000_0000, 32'h0000_0004);
      add(0, 0, 3'b111,  0, 32'h0,         0, 32'h0000_0008, 32'h2222_0004, 1, 1, 32'h0000_0004, 32'h0000_0008);

      // reset for two cycles
      drive(1, 0, NPC_SEQ, 0, 32'h0);
      step();
      step();
      check_regs("reset", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
      check("reset redirectF", {31'd0, redirectF}, 32'd0);

      foreach (rows[i]) begin
         string tag;
         tag = $sformatf("row%0d", i);
         drive(rows[i].rst, rows[i].stall, rows[i].op, rows[i].eq, rows[i].rs);
         check({tag, " redirectF"}, {31'd0, redirectF}, {31'd0, rows[i].exp_redirect});
         step();
         check_regs(tag, rows[i].exp_addr, rows[i].exp_instr, rows[i].exp_valid,
                    rows[i].chk_pc, rows[i].exp_pcd, rows[i].exp_pc4);
      end

      // ID holds W1 @4, PC=8: taken jr while stalled stays frozen
      drive(0, 1, NPC_JR, 0, 32'h0000_0100);
      check("stall jr redirectF", {31'd0, redirectF}, 32'd0);
      step();
      check_regs("stall jr", 32'h8, 32'h2222_0004, 1'b1, 1'b1, 32'h4, 32'h8);

      // reset during the stall wins in one edge
      drive(1, 1, NPC_JR, 0, 32'h0000_0100);
      step();
      check_regs("rst in stall", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
      check("rst in stall redirectF", {31'd0, redirectF}, 32'd0);

      drive(0, 0, NPC_SEQ, 0, 32'h0);
      step();
      check_regs("post rst", 32'h4, 32'h1111_0000, 1'b1, 1'b1, 32'h0, 32'h4);

      // reset during a redirect wins as well
      drive(1, 0, NPC_J, 0, 32'h0);
      check("rst in redirect redirectF", {31'd0, redirectF}, 32'd1);
      step();
      check_regs("rst in redirect", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
